// File: rtl/press_arbiter_if.sv
// Handshake and result bundle between the reaction-game controller and the
// press arbiter. The controller/bench side is the master, the arbiter the slave.
interface press_arbiter_if #(
  parameter int TIME_W = 10
);
  logic              ARM;
  logic              GO;
  logic              PLAYER_A;
  logic              PLAYER_B;
  logic              ACK;
  logic              RESULT_VALID;
  logic [1:0]        WINNER;
  logic              FALSE_START;
  logic              TIMEOUT;
  logic [TIME_W-1:0] REACT_TIME;
  logic              TIE_PRIO;

  modport master (
    output ARM, GO, PLAYER_A, PLAYER_B, ACK,
    input  RESULT_VALID, WINNER, FALSE_START, TIMEOUT, REACT_TIME, TIE_PRIO
  );

  modport slave (
    input  ARM, GO, PLAYER_A, PLAYER_B, ACK,
    output RESULT_VALID, WINNER, FALSE_START, TIMEOUT, REACT_TIME, TIE_PRIO
  );
endinterface

// File: rtl/press_arbiter.sv
// Two-player reaction arbiter: synchronizes the raw active-low buttons, turns
// them into one-cycle press pulses, and decides false starts, winners, ties
// (with alternating tie priority) and timeouts. Results are held until ACK.
module press_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int TIME_W      = 10
) (
  input logic           CLK,
  input logic           RESET,
  press_arbiter_if.slave bus
);

  // Fewer than two stages would not be a real synchronizer.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, ARMED, TIMING, RESULT} state_t;

  // Bit 0 = player A, bit 1 = player B, so a single pulse maps directly onto
  // the WINNER encoding (01 = A, 10 = B).
  logic [1:0] raw_btn;
  logic [1:0] press_pulse;

  assign raw_btn = {bus.PLAYER_B, bus.PLAYER_A};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [SYNC_N-1:0] sync_q;
      logic [SYNC_N-1:0] sync_d;
      logic              prev_q;
      logic              prev_d;
      logic              pulse_q;
      logic              pulse_d;

      // Shift the raw button in; a press is a 1-to-0 step of the synchronized
      // level, registered once more so the pulse lands SYNC_N+1 cycles after
      // the raw edge.
      always_comb begin
        sync_d  = {sync_q[SYNC_N-2:0], raw_btn[gi]};
        prev_d  = sync_q[SYNC_N-1];
        pulse_d = prev_q & ~sync_q[SYNC_N-1];
      end

      // Synchronizer and edge-detector registers; reset to "released".
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          sync_q  <= '1;
          prev_q  <= 1'b1;
          pulse_q <= 1'b0;
        end else begin
          sync_q  <= sync_d;
          prev_q  <= prev_d;
          pulse_q <= pulse_d;
        end
      end

      assign press_pulse[gi] = pulse_q;
    end
  endgenerate

  state_t            state_q, state_d;
  logic [TIME_W-1:0] timer_q, timer_d;
  logic              valid_q, valid_d;
  logic [1:0]        winner_q, winner_d;
  logic              false_start_q, false_start_d;
  logic              timeout_q, timeout_d;
  logic [TIME_W-1:0] react_q, react_d;
  logic              tie_prio_q, tie_prio_d;

  // Round sequencing; result fields are computed here and only change when
  // entering or leaving RESULT, so they stay stable while RESULT_VALID is high.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    valid_d       = valid_q;
    winner_d      = winner_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    react_d       = react_q;
    tie_prio_d    = tie_prio_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bus.ARM) state_d = ARMED;
      end
      ARMED: begin
        if (!bus.ARM) begin
          state_d = IDLE;
        end else if (press_pulse != 2'b00) begin
          // Early press: the opponent wins; a simultaneous early press has no winner.
          state_d       = RESULT;
          valid_d       = 1'b1;
          false_start_d = 1'b1;
          case (press_pulse)
            2'b01:   winner_d = 2'b10;
            2'b10:   winner_d = 2'b01;
            default: winner_d = 2'b00;
          endcase
        end else if (bus.GO) begin
          state_d = TIMING;
          timer_d = '0;
        end
      end
      TIMING: begin
        if (!bus.ARM) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (press_pulse != 2'b00) begin
          state_d = RESULT;
          valid_d = 1'b1;
          react_d = timer_q;
          if (press_pulse == 2'b11) begin
            winner_d   = tie_prio_q ? 2'b10 : 2'b01;
            tie_prio_d = ~tie_prio_q;
          end else begin
            winner_d = press_pulse;
          end
        end else if (timer_q == '1) begin
          state_d   = RESULT;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          winner_d  = 2'b00;
          react_d   = '1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESULT: begin
        if (bus.ACK) begin
          state_d       = IDLE;
          valid_d       = 1'b0;
          winner_d      = 2'b00;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs; reset abandons any round in progress.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      valid_q       <= 1'b0;
      winner_q      <= 2'b00;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      react_q       <= '0;
      tie_prio_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      valid_q       <= valid_d;
      winner_q      <= winner_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
      react_q       <= react_d;
      tie_prio_q    <= tie_prio_d;
    end
  end

  assign bus.RESULT_VALID = valid_q;
  assign bus.WINNER       = winner_q;
  assign bus.FALSE_START  = false_start_q;
  assign bus.TIMEOUT      = timeout_q;
  assign bus.REACT_TIME   = react_q;
  assign bus.TIE_PRIO     = tie_prio_q;

endmodule

// File: tb/tb_press_arbiter.sv
// Directed self-checking bench for press_arbiter. Two instances share the
// clock and reset: the default one (TIME_W=10) and a TIME_W=4 one for timeout.
module tb_press_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  press_arbiter_if #(.TIME_W(10)) bus ();
  press_arbiter_if #(.TIME_W(4))  bus4 ();

  press_arbiter #(.SYNC_STAGES(2), .TIME_W(10)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  press_arbiter #(.SYNC_STAGES(2), .TIME_W(4)) dut4 (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ARM = 0; bus.GO = 0; bus.PLAYER_A = 1; bus.PLAYER_B = 1; bus.ACK = 0;
    bus4.ARM = 0; bus4.GO = 0; bus4.PLAYER_A = 1; bus4.PLAYER_B = 1; bus4.ACK = 0;
    step(2);
    checks++;
    if (bus.RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.RESULT_VALID); end
    checks++;
    if (bus.WINNER !== 2'b00) begin errors++; $display("FAIL reset_winner: got %b expected 00", bus.WINNER); end
    checks++;
    if (bus.REACT_TIME !== 10'd0) begin errors++; $display("FAIL reset_react: got %0d expected 0", bus.REACT_TIME); end
    checks++;
    if (bus.TIE_PRIO !== 1'b0 || bus.FALSE_START !== 1'b0 || bus.TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got tie=%b fs=%b to=%b expected 0 0 0", bus.TIE_PRIO, bus.FALSE_START, bus.TIMEOUT);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_normal_win();
    bus.ARM = 1; step(1);          // IDLE -> ARMED
    bus.GO = 1;  step(1);          // ARMED -> TIMING, timer = 0
    step(5);                       // timer = 5
    bus.PLAYER_A = 0;
    step(3);
    checks++;
    if (bus.RESULT_VALID !== 1'b0) begin errors++; $display("FAIL win_not_early: got %b expected 0", bus.RESULT_VALID); end
    step(1);
    checks++;
    if (bus.RESULT_VALID !== 1'b1) begin errors++; $display("FAIL win_valid: got %b expected 1", bus.RESULT_VALID); end
    checks++;
    if (bus.WINNER !== 2'b01) begin errors++; $display("FAIL win_winner: got %b expected 01", bus.WINNER); end
    checks++;
    if (bus.REACT_TIME !== 10'd8) begin errors++; $display("FAIL win_react: got %0d expected 8", bus.REACT_TIME); end
    checks++;
    if (bus.FALSE_START !== 1'b0 || bus.TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL win_flags: got fs=%b to=%b expected 0 0", bus.FALSE_START, bus.TIMEOUT);
    end
    // ARM/GO drop and a fresh B press while in RESULT must not disturb the result.
    bus.ARM = 0; bus.GO = 0; bus.PLAYER_A = 1; bus.PLAYER_B = 0;
    step(6);
    checks++;
    if (bus.RESULT_VALID !== 1'b1 || bus.WINNER !== 2'b01 || bus.REACT_TIME !== 10'd8) begin
      errors++; $display("FAIL win_hold: got v=%b w=%b rt=%0d expected 1 01 8", bus.RESULT_VALID, bus.WINNER, bus.REACT_TIME);
    end
    bus.PLAYER_B = 1;
    bus.ACK = 1; step(1); bus.ACK = 0;
    checks++;
    if (bus.RESULT_VALID !== 1'b0 || bus.WINNER !== 2'b00) begin
      errors++; $display("FAIL win_ack: got v=%b w=%b expected 0 00", bus.RESULT_VALID, bus.WINNER);
    end
    checks++;
    if (bus.REACT_TIME !== 10'd8) begin errors++; $display("FAIL win_react_kept: got %0d expected 8", bus.REACT_TIME); end
    step(4);
  endtask

  task automatic test_false_start();
    bus.ARM = 1; step(1);          // ARMED
    bus.PLAYER_B = 0;
    step(3);                       // B pulse is live this cycle
    bus.GO = 1;                    // press must beat GO
    step(1);
    checks++;
    if (bus.RESULT_VALID !== 1'b1 || bus.FALSE_START !== 1'b1) begin
      errors++; $display("FAIL fs_flag: got v=%b fs=%b expected 1 1", bus.RESULT_VALID, bus.FALSE_START);
    end
    checks++;
    if (bus.WINNER !== 2'b01) begin errors++; $display("FAIL fs_winner: got %b expected 01", bus.WINNER); end
    checks++;
    if (bus.TIMEOUT !== 1'b0 || bus.REACT_TIME !== 10'd8) begin
      errors++; $display("FAIL fs_other: got to=%b rt=%0d expected 0 8", bus.TIMEOUT, bus.REACT_TIME);
    end
    step(5);
    checks++;
    if (bus.RESULT_VALID !== 1'b1 || bus.FALSE_START !== 1'b1 || bus.WINNER !== 2'b01) begin
      errors++; $display("FAIL fs_hold: got v=%b fs=%b w=%b expected 1 1 01", bus.RESULT_VALID, bus.FALSE_START, bus.WINNER);
    end
    bus.PLAYER_B = 1; bus.ARM = 0; bus.GO = 0;
    bus.ACK = 1; step(1); bus.ACK = 0;
    checks++;
    if (bus.RESULT_VALID !== 1'b0 || bus.FALSE_START !== 1'b0) begin
      errors++; $display("FAIL fs_ack: got v=%b fs=%b expected 0 0", bus.RESULT_VALID, bus.FALSE_START);
    end
    step(4);
  endtask

  // One tied round starting from IDLE; checks winner, reaction time and new priority.
  task automatic tie_round(input logic [1:0] exp_winner, input logic exp_prio);
    bus.ARM = 1; step(1);
    bus.GO = 1;  step(1);          // timer = 0
    step(2);                       // timer = 2
    bus.PLAYER_A = 0; bus.PLAYER_B = 0;
    step(4);
    checks++;
    if (bus.RESULT_VALID !== 1'b1 || bus.WINNER !== exp_winner) begin
      errors++; $display("FAIL tie_winner: got v=%b w=%b expected 1 %b", bus.RESULT_VALID, bus.WINNER, exp_winner);
    end
    checks++;
    if (bus.REACT_TIME !== 10'd5) begin errors++; $display("FAIL tie_react: got %0d expected 5", bus.REACT_TIME); end
    checks++;
    if (bus.TIE_PRIO !== exp_prio) begin errors++; $display("FAIL tie_prio: got %b expected %b", bus.TIE_PRIO, exp_prio); end
    bus.PLAYER_A = 1; bus.PLAYER_B = 1; bus.ARM = 0; bus.GO = 0;
    bus.ACK = 1; step(1); bus.ACK = 0;
    step(4);
  endtask

  task automatic test_tie();
    tie_round(2'b01, 1'b1);
    tie_round(2'b10, 1'b0);
    checks++;
    if (bus.TIE_PRIO !== 1'b0) begin errors++; $display("FAIL tie_prio_end: got %b expected 0", bus.TIE_PRIO); end
  endtask

  task automatic test_held_button();
    bus.PLAYER_A = 0;              // pressed while idle: pulse is thrown away
    step(5);
    bus.ARM = 1; step(1);
    bus.GO = 1;  step(1);
    step(3);                       // timer = 3
    bus.PLAYER_B = 0;
    step(4);
    checks++;
    if (bus.RESULT_VALID !== 1'b1 || bus.WINNER !== 2'b10) begin
      errors++; $display("FAIL held_winner: got v=%b w=%b expected 1 10", bus.RESULT_VALID, bus.WINNER);
    end
    checks++;
    if (bus.REACT_TIME !== 10'd6 || bus.FALSE_START !== 1'b0) begin
      errors++; $display("FAIL held_react: got rt=%0d fs=%b expected 6 0", bus.REACT_TIME, bus.FALSE_START);
    end
    bus.PLAYER_A = 1; bus.PLAYER_B = 1; bus.ARM = 0; bus.GO = 0;
    bus.ACK = 1; step(1); bus.ACK = 0;
    step(4);
  endtask

  task automatic test_timeout();
    bus4.ARM = 1; step(1);
    bus4.GO = 1;  step(1);         // timer = 0
    step(15);                      // timer = 15, still counting
    checks++;
    if (bus4.RESULT_VALID !== 1'b0) begin errors++; $display("FAIL to_not_early: got %b expected 0", bus4.RESULT_VALID); end
    step(1);
    checks++;
    if (bus4.RESULT_VALID !== 1'b1 || bus4.TIMEOUT !== 1'b1) begin
      errors++; $display("FAIL to_flag: got v=%b to=%b expected 1 1", bus4.RESULT_VALID, bus4.TIMEOUT);
    end
    checks++;
    if (bus4.WINNER !== 2'b00 || bus4.REACT_TIME !== 4'hF) begin
      errors++; $display("FAIL to_result: got w=%b rt=%h expected 00 f", bus4.WINNER, bus4.REACT_TIME);
    end
    checks++;
    if (bus4.FALSE_START !== 1'b0) begin errors++; $display("FAIL to_fs: got %b expected 0", bus4.FALSE_START); end
    bus4.ARM = 0; bus4.GO = 0;
    bus4.ACK = 1; step(1); bus4.ACK = 0;
    checks++;
    if (bus4.RESULT_VALID !== 1'b0 || bus4.TIMEOUT !== 1'b0) begin
      errors++; $display("FAIL to_ack: got v=%b to=%b expected 0 0", bus4.RESULT_VALID, bus4.TIMEOUT);
    end
    step(2);
  endtask

  task automatic test_abort();
    bus.ARM = 1; step(1);          // ARMED
    step(2);
    bus.ARM = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if (bus.RESULT_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid: cycle %0d got %b expected 0", i, bus.RESULT_VALID); end
    end
  endtask

  task automatic test_async_reset();
    tie_round(2'b01, 1'b1);        // leaves TIE_PRIO=1 and REACT_TIME=5 to be cleared
    bus.ARM = 1; step(1);
    bus.GO = 1;  step(3);          // mid-TIMING
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.TIE_PRIO !== 1'b0 || bus.REACT_TIME !== 10'd0) begin
      errors++; $display("FAIL areset_clear: got tie=%b rt=%0d expected 0 0", bus.TIE_PRIO, bus.REACT_TIME);
    end
    checks++;
    if (bus.RESULT_VALID !== 1'b0 || bus.WINNER !== 2'b00) begin
      errors++; $display("FAIL areset_outs: got v=%b w=%b expected 0 00", bus.RESULT_VALID, bus.WINNER);
    end
    bus.ARM = 0; bus.GO = 0;
    step(2);
    rst_n = 1'b1;
    // Fresh round straight after reset release: A at timer 0 -> reaction 3.
    bus.ARM = 1; step(1);
    bus.GO = 1;  step(1);
    bus.PLAYER_A = 0;
    step(4);
    checks++;
    if (bus.RESULT_VALID !== 1'b1 || bus.WINNER !== 2'b01 || bus.REACT_TIME !== 10'd3) begin
      errors++; $display("FAIL areset_resume: got v=%b w=%b rt=%0d expected 1 01 3", bus.RESULT_VALID, bus.WINNER, bus.REACT_TIME);
    end
    bus.PLAYER_A = 1; bus.ARM = 0; bus.GO = 0;
    bus.ACK = 1; step(1); bus.ACK = 0;
    step(2);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_normal_win();
    test_false_start();
    test_tie();
    test_held_button();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
